// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared state codes, default widths and PC reset vector
package instr_sequencer_pkg;
    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 32;
    localparam int RET_W_DEF   = 16;
    localparam int PC_RST      = 0;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: memory, execute-unit and status signals of the sequencer
interface instr_sequencer_if import instr_sequencer_pkg::*; #(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int RET_W   = RET_W_DEF
);
    logic               start;
    logic               imem_ack;
    logic [INSTR_W-1:0] instr_in;
    logic               is_halt;
    logic               exec_done;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    pc_counter;
    logic               imem_req;
    logic [INSTR_W-1:0] instr_reg;
    logic               exec_start;
    logic               reg_we;
    logic               running;
    logic               halted;
    logic [2:0]         state;
    logic [RET_W-1:0]   retired;
    modport master (
        input  start, imem_ack, instr_in, is_halt, exec_done, branch_taken, branch_target,
        output pc_counter, imem_req, instr_reg, exec_start, reg_we, running, halted, state, retired
    );
    modport slave (
        output start, imem_ack, instr_in, is_halt, exec_done, branch_taken, branch_target,
        input  pc_counter, imem_req, instr_reg, exec_start, reg_we, running, halted, state, retired
    );
endinterface

// File: rtl/instr_sequencer_pc_reg.sv
// instr_sequencer_pc_reg: program counter with load, wrapping increment and async reset
module instr_sequencer_pc_reg import instr_sequencer_pkg::*; #(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);
    logic [PC_W-1:0] pc_q;
    // load has priority over increment; increment wraps modulo 2^PC_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= PC_W'(PC_RST);
        else if (load_i) pc_q <= target_i;
        else if (inc_i) pc_q <= pc_q + PC_W'(1);
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute/writeback controller owning the program counter
module instr_sequencer import instr_sequencer_pkg::*; #(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int RET_W   = RET_W_DEF
) (
    input  logic clk,
    input  logic rst,
    instr_sequencer_if.master bus
);
    logic [2:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic               br_q;
    logic [PC_W-1:0]    tgt_q;
    logic               exec_start_q;
    logic [RET_W-1:0]   ret_q;
    logic [PC_W-1:0]    pc;
    logic               wb;
    // next state; illegal codes fall back to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = bus.start ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = bus.imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_d = bus.is_halt ? S_HALT : S_EXEC;
            S_EXEC:   state_d = bus.exec_done ? S_WB : S_EXEC;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end
    // state, instruction latch, branch capture, exec_start pulse and saturating retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            br_q         <= 1'b0;
            tgt_q        <= '0;
            exec_start_q <= 1'b0;
            ret_q        <= '0;
        end else begin
            state_q      <= state_d;
            exec_start_q <= state_q == S_DECODE && !bus.is_halt;
            if (state_q == S_FETCH && bus.imem_ack) instr_q <= bus.instr_in;
            if (state_q == S_EXEC && bus.exec_done) begin
                br_q  <= bus.branch_taken;
                tgt_q <= bus.branch_target;
            end
            if (state_q == S_WB && ret_q != '1) ret_q <= ret_q + RET_W'(1);
        end
    end
    assign wb = state_q == S_WB;
    instr_sequencer_pc_reg #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_i   (wb && br_q),
        .inc_i    (wb && !br_q),
        .target_i (tgt_q),
        .pc_o     (pc)
    );
    assign bus.pc_counter = pc;
    assign bus.imem_req   = state_q == S_FETCH;
    assign bus.instr_reg  = instr_q;
    assign bus.exec_start = exec_start_q;
    assign bus.reg_we     = wb;
    assign bus.running    = state_q >= S_FETCH && state_q <= S_WB;
    assign bus.halted     = state_q == S_HALT;
    assign bus.state      = state_q;
    assign bus.retired    = ret_q;
endmodule
